lcd_val_sched: RTL and testbench
================================

# lcd_val_sched

Scheduler and arbiter for the LCD value bus feeding `lcddrive`. It accepts display updates (SpO2, heart rate, wattage; BCD digits) from two requesters, the APB register block and a secondary source, over valid/ready handshakes. It grants them round-robin, latches the winner, and issues a stretched `VAL_STB`. A mandatory hold-off then lets the slower `periCLK` LCD domain capture stable values. It sits between `apb3_to_lcddata` and `lcddrive` in the `io_systemClk` domain.

## Interface
- `STB_WIDTH`, 8: cycles `VAL_STB` is held high (≥1).
- `HOLDOFF_CYC`, 4096: idle cycles after strobe before the next grant (≥1).
- `TP_PERIOD`, 25000000: test-pattern step period in cycles (only used with `LCD_SCHED_TESTPAT_EN`).
- `clk`  in  1  `io_systemClk`. One clock only.
- `resetn`  in  1  async active-low reset. Tie to `io_pllLocked`.
- `a_valid`  in  1  host (APB) update request.
- `a_ready`  out  1  host update accepted (1-cycle pulse).
- `a_spo2`, `a_heart`  in  12 each  3 BCD digits.
- `a_watt`  in  20  5 BCD digits.
- `b_valid`, `b_ready`, `b_spo2`, `b_heart`, `b_watt`  same as port A, for the secondary requester.
- `VAL_SPO2`  out  12  to `lcddrive`.
- `VAL_HEARTRATE`  out  12  to `lcddrive`.
- `VAL_WATT`  out  20  to `lcddrive`.
- `VAL_STB`  out  1  update strobe, stretched.
- `busy`  out  1  high in every state except IDLE.
- `last_src`  out  1  source of the current `VAL_*` (0=A, 1=B).

## Operation
- FSM: IDLE → LOAD → SETUP → STROBE → HOLD → IDLE.
- IDLE: if any valid is set, pick a grant and go to LOAD. Otherwise stay.
- Arbitration is round-robin on the last-grant pointer `rr`; `rr` resets to B, so A wins the first tie. If only one valid is set, that requester wins regardless of `rr`. `rr` updates on grant.
- LOAD: assert the granted `x_ready` for exactly this cycle. Capture the granted data into `VAL_*` at the end of the cycle. Update `last_src`.
- Digit sanitising at capture: any nibble > 9 is stored as 4'hF (blank glyph for `lcddrive`). Nibbles 0–9 pass unchanged. No other arithmetic.
- SETUP: one cycle with `VAL_*` stable and `VAL_STB` low, giving cross-domain setup.
- STROBE: `VAL_STB` high for `STB_WIDTH` cycles, counted by a down-counter.
- HOLD: `HOLDOFF_CYC` cycles with `VAL_STB` low. Valids are ignored. `VAL_*` is never modified outside LOAD.
- Handshake rule: a requester holds valid and data stable until it sees ready.
  - A valid dropped before grant is simply not served.
  - A valid that stays high after ready is treated as a new request.
- Both valids rising in the same cycle: the one selected by `rr` is served. The other waits at most one full update period.
- Reset, including mid-STROBE or mid-HOLD, returns to IDLE immediately. Reset values:
  - `VAL_*`=0, `VAL_STB`=0
  - `a_ready`=`b_ready`=0
  - `busy`=0, `last_src`=0, `rr`=B
  - counters=0

## Timing
- Valid seen in IDLE at cycle n:
  - state=LOAD and `x_ready`=1 at n+1
  - `VAL_*` update at n+2
  - `VAL_STB`=1 for cycles n+3 … n+2+`STB_WIDTH`
- Minimum spacing between `VAL_STB` rising edges: `STB_WIDTH`+`HOLDOFF_CYC`+3 cycles.
- `VAL_*`, `VAL_STB`, `busy` and `last_src` are registered outputs. `x_ready` is decoded from state and grant registers, with no combinational path from valid.

## Configuration
- `LCD_SCHED_TESTPAT_EN` defined:
  - Port B is driven internally by a test-pattern generator. External `b_*` inputs are ignored, and `b_ready` is still driven as observable status.
  - Every `TP_PERIOD` cycles the generator increments a digit counter d (0–9, wraps 9→0).
  - It then requests with every nibble = d: SpO2=0xddd, HR=0xddd, watt=0xddddd.
- Not defined: port B comes from the external `b_*` pins. The generator is not built.

## Structure
- Package `lcd_sched_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_LOAD`, `ST_SETUP`, `ST_STROBE`, `ST_HOLD`)
  - width constants `SPO2_W`=12, `HR_W`=12, `WATT_W`=20
  - `DIGIT_BLANK`=4'hF
  - the nibble-sanitise function
- Sub-module `lcd_testpat_gen`: period counter, digit counter and valid/ready request logic. It is instantiated only under `LCD_SCHED_TESTPAT_EN`.

## Test plan
- Single A request (spo2=0x098, heart=0x072, watt=0x01234), `STB_WIDTH`=4, `HOLDOFF_CYC`=16 → `a_ready` at n+1, `VAL_*` equal to the inputs at n+2, `VAL_STB` high n+3..n+6, `busy` low at n+23.
- A and B valid in the same cycle from reset → A served first (`last_src`=0), B served immediately after HOLD (`last_src`=1), strobe edges 23 cycles apart.
- A held continuously valid with B idle, then B asserted → A and B served alternately. B waits no more than one update period.
- Nibble sanitise: a_watt=0x1A3F9 → `VAL_WATT`=0x1F3F9; a_spo2=0xB00 → `VAL_SPO2`=0xF00.
- Reset pulsed during STROBE → `VAL_STB`, `VAL_*` and `busy` go to 0 asynchronously. A pending request is served normally after release.
- With `LCD_SCHED_TESTPAT_EN` and `TP_PERIOD`=100 → every 100 cycles `VAL_SPO2` steps 0x000, 0x111 … 0x999, then wraps to 0x000, with `last_src`=1.

Source files
------------

// File: rtl/lcd_sched_pkg.sv
// Shared types, widths and digit sanitising for the LCD value scheduler.
package lcd_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;

    localparam int SPO2_W = 12;
    localparam int HR_W   = 12;
    localparam int WATT_W = 20;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    // Non-decimal nibbles become the blank glyph understood by lcddrive.
    function automatic logic [3:0] sanitizeNibble(input logic [3:0] d);
        return (d > 4'd9) ? DIGIT_BLANK : d;
    endfunction

endpackage

// File: rtl/lcd_testpat_gen.sv
// Test-pattern requester: every TP_PERIOD cycles raises a request with all digits = d, then steps d 0..9.
// Latency: request one cycle after the period tick; holds valid and data until ready, digit advances on ready.
module lcd_testpat_gen
    import lcd_sched_pkg::*;
#(
    parameter int TP_PERIOD = 25000000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              tpReady,
    output logic              tpValid,
    output logic [SPO2_W-1:0] tpSpo2,
    output logic [HR_W-1:0]   tpHeart,
    output logic [WATT_W-1:0] tpWatt
);

    localparam int PW = (TP_PERIOD > 1) ? $clog2(TP_PERIOD) : 1;
    localparam logic [PW-1:0] PERIOD_LAST = PW'(TP_PERIOD - 1);

    logic [PW-1:0] periodCnt;
    logic [3:0]    digit;
    logic          periodTick;

    assign periodTick = (periodCnt == PERIOD_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            periodCnt <= '0;
            digit     <= 4'd0;
            tpValid   <= 1'b0;
        end else begin
            periodCnt <= periodTick ? '0 : periodCnt + 1'b1;
            if (tpReady) begin
                tpValid <= 1'b0;
                digit   <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
            end
            // A fresh tick wins over the completing handshake.
            if (periodTick) begin
                tpValid <= 1'b1;
            end
        end
    end

    assign tpSpo2  = {(SPO2_W/4){digit}};
    assign tpHeart = {(HR_W/4){digit}};
    assign tpWatt  = {(WATT_W/4){digit}};

endmodule

// File: rtl/lcd_val_sched.sv
// Round-robin scheduler for LCD value updates: LOAD, SETUP, stretched VAL_STB, then a hold-off.
// Ready pulses 1 cycle after valid is seen in IDLE; no requests are taken from LOAD until back in IDLE.
// LCD_SCHED_TESTPAT_EN replaces port B with the internal test-pattern generator.
module lcd_val_sched
    import lcd_sched_pkg::*;
#(
    parameter int STB_WIDTH   = 8,
    parameter int HOLDOFF_CYC = 4096,
    parameter int TP_PERIOD   = 25000000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [SPO2_W-1:0] a_spo2,
    input  logic [HR_W-1:0]   a_heart,
    input  logic [WATT_W-1:0] a_watt,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [SPO2_W-1:0] b_spo2,
    input  logic [HR_W-1:0]   b_heart,
    input  logic [WATT_W-1:0] b_watt,
    output logic [SPO2_W-1:0] VAL_SPO2,
    output logic [HR_W-1:0]   VAL_HEARTRATE,
    output logic [WATT_W-1:0] VAL_WATT,
    output logic              VAL_STB,
    output logic              busy,
    output logic              last_src
);

    localparam int CNT_MAX = (STB_WIDTH > HOLDOFF_CYC) ? STB_WIDTH : HOLDOFF_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STB_LOAD  = CNT_W'(STB_WIDTH - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYC - 1);

    logic              bValid;
    logic [SPO2_W-1:0] bSpo2;
    logic [HR_W-1:0]   bHeart;
    logic [WATT_W-1:0] bWatt;

`ifdef LCD_SCHED_TESTPAT_EN
    logic unusedBPins;
    assign unusedBPins = ^{b_valid, b_spo2, b_heart, b_watt};

    lcd_testpat_gen #(
        .TP_PERIOD (TP_PERIOD)
    ) u_testpat (
        .clk     (clk),
        .resetn  (resetn),
        .tpReady (b_ready),
        .tpValid (bValid),
        .tpSpo2  (bSpo2),
        .tpHeart (bHeart),
        .tpWatt  (bWatt)
    );
`else
    localparam int unusedTpPeriod = TP_PERIOD;

    assign bValid = b_valid;
    assign bSpo2  = b_spo2;
    assign bHeart = b_heart;
    assign bWatt  = b_watt;
`endif

    state_t            state, nextState;
    logic              grant, rr, pick, anyValid, cntZero;
    logic              stbNext, busyNext;
    logic [CNT_W-1:0]  cnt;
    logic [SPO2_W-1:0] selSpo2, cleanSpo2;
    logic [HR_W-1:0]   selHeart, cleanHeart;
    logic [WATT_W-1:0] selWatt, cleanWatt;

    assign anyValid = a_valid | bValid;
    assign cntZero  = (cnt == '0);
    // On a tie the requester not granted last time wins; a lone requester always wins.
    assign pick     = (a_valid && bValid) ? ~rr : bValid;

    always_comb begin
        selSpo2    = grant ? bSpo2  : a_spo2;
        selHeart   = grant ? bHeart : a_heart;
        selWatt    = grant ? bWatt  : a_watt;
        cleanSpo2  = '0;
        cleanHeart = '0;
        cleanWatt  = '0;
        for (int i = 0; i < SPO2_W/4; i++) cleanSpo2[i*4 +: 4]  = sanitizeNibble(selSpo2[i*4 +: 4]);
        for (int i = 0; i < HR_W/4; i++)   cleanHeart[i*4 +: 4] = sanitizeNibble(selHeart[i*4 +: 4]);
        for (int i = 0; i < WATT_W/4; i++) cleanWatt[i*4 +: 4]  = sanitizeNibble(selWatt[i*4 +: 4]);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:   if (anyValid) nextState = ST_LOAD;
            ST_LOAD:   nextState = ST_SETUP;
            ST_SETUP:  nextState = ST_STROBE;
            ST_STROBE: if (cntZero) nextState = ST_HOLD;
            ST_HOLD:   if (cntZero) nextState = ST_IDLE;
            default:   nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        a_ready  = (state == ST_LOAD) && !grant;
        b_ready  = (state == ST_LOAD) &&  grant;
        stbNext  = (nextState == ST_STROBE);
        busyNext = (nextState != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant         <= 1'b0;
            rr            <= 1'b1;
            cnt           <= '0;
            VAL_SPO2      <= '0;
            VAL_HEARTRATE <= '0;
            VAL_WATT      <= '0;
            VAL_STB       <= 1'b0;
            busy          <= 1'b0;
            last_src      <= 1'b0;
        end else begin
            VAL_STB <= stbNext;
            busy    <= busyNext;
            if (state == ST_IDLE && anyValid) begin
                grant <= pick;
                rr    <= pick;
            end
            if (state == ST_LOAD) begin
                VAL_SPO2      <= cleanSpo2;
                VAL_HEARTRATE <= cleanHeart;
                VAL_WATT      <= cleanWatt;
                last_src      <= grant;
            end
            // One down-counter serves both the strobe width and the hold-off.
            if (state == ST_SETUP)                cnt <= STB_LOAD;
            else if (state == ST_STROBE && cntZero) cnt <= HOLD_LOAD;
            else if (!cntZero)                    cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_val_sched.sv
// Directed bench for lcd_val_sched with STB_WIDTH=4, HOLDOFF_CYC=16 (update period 23 cycles).
module tb_lcd_val_sched;
    import lcd_sched_pkg::*;

    localparam int SW = 4;
    localparam int HO = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [11:0] a_spo2 = '0, a_heart = '0, b_spo2 = '0, b_heart = '0;
    logic [19:0] a_watt = '0, b_watt = '0;
    logic [11:0] VAL_SPO2, VAL_HEARTRATE;
    logic [19:0] VAL_WATT;
    logic        VAL_STB, busy, last_src;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lcd_val_sched #(
        .STB_WIDTH   (SW),
        .HOLDOFF_CYC (HO),
        .TP_PERIOD   (100)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .a_valid       (a_valid),
        .a_ready       (a_ready),
        .a_spo2        (a_spo2),
        .a_heart       (a_heart),
        .a_watt        (a_watt),
        .b_valid       (b_valid),
        .b_ready       (b_ready),
        .b_spo2        (b_spo2),
        .b_heart       (b_heart),
        .b_watt        (b_watt),
        .VAL_SPO2      (VAL_SPO2),
        .VAL_HEARTRATE (VAL_HEARTRATE),
        .VAL_WATT      (VAL_WATT),
        .VAL_STB       (VAL_STB),
        .busy          (busy),
        .last_src      (last_src)
    );

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic driveA(input logic v, input logic [11:0] s, input logic [11:0] h, input logic [19:0] w);
        a_valid = v; a_spo2 = s; a_heart = h; a_watt = w;
    endtask

    task automatic driveB(input logic v, input logic [11:0] s, input logic [11:0] h, input logic [19:0] w);
        b_valid = v; b_spo2 = s; b_heart = h; b_watt = w;
    endtask

    task automatic waitIdle(output logic ok);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            step(1);
            n++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic test_reset();
        logic [11:0] zero12 = '0;
        logic [19:0] zero20 = '0;
        resetn = 1'b0;
        step(2);
        checks++; if (VAL_SPO2 !== zero12)      begin errors++; $display("FAIL reset_spo2 got %h exp %h", VAL_SPO2, zero12); end
        checks++; if (VAL_HEARTRATE !== zero12) begin errors++; $display("FAIL reset_heart got %h exp %h", VAL_HEARTRATE, zero12); end
        checks++; if (VAL_WATT !== zero20)      begin errors++; $display("FAIL reset_watt got %h exp %h", VAL_WATT, zero20); end
        checks++; if (VAL_STB !== 1'b0)         begin errors++; $display("FAIL reset_stb got %b exp 0", VAL_STB); end
        checks++; if (busy !== 1'b0)            begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (last_src !== 1'b0)        begin errors++; $display("FAIL reset_last_src got %b exp 0", last_src); end
        checks++; if (a_ready !== 1'b0)         begin errors++; $display("FAIL reset_a_ready got %b exp 0", a_ready); end
        checks++; if (b_ready !== 1'b0)         begin errors++; $display("FAIL reset_b_ready got %b exp 0", b_ready); end
        resetn = 1'b1;
        step(1);
    endtask

    task automatic test_single();
        driveA(1'b1, 12'h098, 12'h072, 20'h01234);
        step(1);  // n+1
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL single_a_ready got %b exp 1", a_ready); end
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL single_b_ready got %b exp 0", b_ready); end
        checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL single_busy_load got %b exp 1", busy); end
        step(1);  // n+2
        a_valid = 1'b0;
        checks++; if (VAL_SPO2 !== 12'h098)      begin errors++; $display("FAIL single_spo2 got %h exp 098", VAL_SPO2); end
        checks++; if (VAL_HEARTRATE !== 12'h072) begin errors++; $display("FAIL single_heart got %h exp 072", VAL_HEARTRATE); end
        checks++; if (VAL_WATT !== 20'h01234)    begin errors++; $display("FAIL single_watt got %h exp 01234", VAL_WATT); end
        checks++; if (VAL_STB !== 1'b0)          begin errors++; $display("FAIL single_stb_setup got %b exp 0", VAL_STB); end
        checks++; if (a_ready !== 1'b0)          begin errors++; $display("FAIL single_ready_pulse got %b exp 0", a_ready); end
        step(1);  // n+3
        checks++; if (VAL_STB !== 1'b1) begin errors++; $display("FAIL single_stb_first got %b exp 1", VAL_STB); end
        step(3);  // n+6
        checks++; if (VAL_STB !== 1'b1) begin errors++; $display("FAIL single_stb_last got %b exp 1", VAL_STB); end
        step(1);  // n+7
        checks++; if (VAL_STB !== 1'b0) begin errors++; $display("FAIL single_stb_end got %b exp 0", VAL_STB); end
        step(15); // n+22
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_hold got %b exp 1", busy); end
        step(1);  // n+23
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got %b exp 0", busy); end
    endtask

    task automatic test_tie();
        resetn = 1'b0;
        step(1);
        resetn = 1'b1;
        driveA(1'b1, 12'h095, 12'h061, 20'h00150);
        driveB(1'b1, 12'h088, 12'h102, 20'h00320);
        step(1);  // A granted first since rr resets to B
        checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL tie_first_grant got a=%b b=%b exp a=1 b=0", a_ready, b_ready); end
        step(1);
        a_valid = 1'b0;
        checks++; if (last_src !== 1'b0)     begin errors++; $display("FAIL tie_last_src_a got %b exp 0", last_src); end
        checks++; if (VAL_SPO2 !== 12'h095) begin errors++; $display("FAIL tie_spo2_a got %h exp 095", VAL_SPO2); end
        step(1);  // first strobe edge at n+3
        checks++; if (VAL_STB !== 1'b1) begin errors++; $display("FAIL tie_stb_a got %b exp 1", VAL_STB); end
        step(21); // n+24: B loaded
        checks++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL tie_second_grant got a=%b b=%b exp a=0 b=1", a_ready, b_ready); end
        step(1);
        b_valid = 1'b0;
        checks++; if (last_src !== 1'b1)     begin errors++; $display("FAIL tie_last_src_b got %b exp 1", last_src); end
        checks++; if (VAL_SPO2 !== 12'h088) begin errors++; $display("FAIL tie_spo2_b got %h exp 088", VAL_SPO2); end
        checks++; if (VAL_WATT !== 20'h00320) begin errors++; $display("FAIL tie_watt_b got %h exp 00320", VAL_WATT); end
        checks++; if (VAL_STB !== 1'b0)      begin errors++; $display("FAIL tie_stb_gap got %b exp 0", VAL_STB); end
        step(1);  // n+26: 23 cycles after the first edge
        checks++; if (VAL_STB !== 1'b1) begin errors++; $display("FAIL tie_stb_b got %b exp 1", VAL_STB); end
    endtask

    task automatic test_alternate();
        logic ok;
        int gCyc[$];
        logic gSrc[$];
        int expCyc[5] = '{1, 24, 47, 70, 93};
        logic expSrc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        waitIdle(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL alt_idle_timeout busy=%b exp 0", busy); end
        driveA(1'b1, 12'h097, 12'h080, 20'h00200);
        for (int c = 1; c <= 95; c++) begin
            step(1);
            if (a_ready === 1'b1) begin gCyc.push_back(c); gSrc.push_back(1'b0); end
            if (b_ready === 1'b1) begin gCyc.push_back(c); gSrc.push_back(1'b1); end
            if (c == 30) driveB(1'b1, 12'h090, 12'h070, 20'h00100);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        checks++; if (gCyc.size() !== 5) begin errors++; $display("FAIL alt_grant_count got %0d exp 5", gCyc.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < gCyc.size()) begin
                checks++;
                if (gCyc[i] !== expCyc[i] || gSrc[i] !== expSrc[i]) begin
                    errors++;
                    $display("FAIL alt_grant_%0d got cyc=%0d src=%b exp cyc=%0d src=%b", i, gCyc[i], gSrc[i], expCyc[i], expSrc[i]);
                end
            end
        end
    endtask

    task automatic test_sanitize();
        logic ok;
        waitIdle(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL san_idle_timeout busy=%b exp 0", busy); end
        driveA(1'b1, 12'hB00, 12'h0C5, 20'h1A3F9);
        step(2);
        a_valid = 1'b0;
        checks++; if (VAL_SPO2 !== 12'hF00)      begin errors++; $display("FAIL san_spo2 got %h exp F00", VAL_SPO2); end
        checks++; if (VAL_HEARTRATE !== 12'h0F5) begin errors++; $display("FAIL san_heart got %h exp 0F5", VAL_HEARTRATE); end
        checks++; if (VAL_WATT !== 20'h1F3F9)    begin errors++; $display("FAIL san_watt got %h exp 1F3F9", VAL_WATT); end
    endtask

    task automatic test_reset_strobe();
        logic ok;
        waitIdle(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_idle_timeout busy=%b exp 0", busy); end
        driveA(1'b1, 12'h321, 12'h456, 20'h78901);
        step(4);  // mid-STROBE; A stays valid as a pending request
        checks++; if (VAL_STB !== 1'b1) begin errors++; $display("FAIL rst_pre_stb got %b exp 1", VAL_STB); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (VAL_STB !== 1'b0)       begin errors++; $display("FAIL rst_async_stb got %b exp 0", VAL_STB); end
        checks++; if (VAL_SPO2 !== 12'h000)   begin errors++; $display("FAIL rst_async_spo2 got %h exp 000", VAL_SPO2); end
        checks++; if (VAL_WATT !== 20'h00000) begin errors++; $display("FAIL rst_async_watt got %h exp 00000", VAL_WATT); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL rst_async_busy got %b exp 0", busy); end
        step(1);
        resetn = 1'b1;
        step(1);
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_resume_ready got %b exp 1", a_ready); end
        step(1);
        a_valid = 1'b0;
        checks++; if (VAL_SPO2 !== 12'h321) begin errors++; $display("FAIL rst_resume_spo2 got %h exp 321", VAL_SPO2); end
        waitIdle(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_final_idle busy=%b exp 0", busy); end
    endtask

    task automatic test_testpat();
        logic [3:0]  d;
        logic [11:0] expSpo2;
        int n;
        for (int i = 0; i < 11; i++) begin
            d = 4'(i % 10);
            expSpo2 = {d, d, d};
            n = 0;
            while (VAL_STB !== 1'b1 && n < 300) begin step(1); n++; end
            checks++; if (VAL_STB !== 1'b1) begin errors++; $display("FAIL tp_strobe_%0d timeout stb=%b exp 1", i, VAL_STB); end
            checks++; if (VAL_SPO2 !== expSpo2) begin errors++; $display("FAIL tp_spo2_%0d got %h exp %h", i, VAL_SPO2, expSpo2); end
            checks++; if (last_src !== 1'b1) begin errors++; $display("FAIL tp_src_%0d got %b exp 1", i, last_src); end
            n = 0;
            while (VAL_STB !== 1'b0 && n < 50) begin step(1); n++; end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifdef LCD_SCHED_TESTPAT_EN
        test_testpat();
`else
        test_single();
        test_tie();
        test_alternate();
        test_sanitize();
        test_reset_strobe();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
